// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hold/flush controller: FSM state
// encoding, hold-flag bit positions and the canonical hold-flag patterns.
package pipe_ctrl_pkg;

  // FSM state encoding, kept as plain constants for compatibility with
  // older consumers of this package.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [1:0] ST_INT   = 2'd3;

  // Bit positions inside hold_flag_o.
  localparam int HOLD_PC    = 0;
  localparam int FLUSH_IFID = 1;
  localparam int FLUSH_IDEX = 2;

  typedef logic [2:0] hold_flag_t;

  // Hold-flag patterns driven to the pipeline registers.
  localparam hold_flag_t HOLD_NONE       = 3'b000;
  localparam hold_flag_t HOLD_PC_ONLY    = 3'b001;
  localparam hold_flag_t FLUSH_IFID_ONLY = 3'b010;
  localparam hold_flag_t FLUSH_JUMP      = 3'b110;
  localparam hold_flag_t HOLD_ALL        = 3'b111;

  // State entered after a PC redirect: with only one flush cycle in total
  // the redirect cycle itself covers it and the FSM goes straight to IDLE.
  function automatic logic [1:0] redirect_state(input int flush_cyc);
    return (flush_cyc > 1) ? ST_FLUSH : ST_IDLE;
  endfunction

endpackage

// File: rtl/pipe_hold_ctrl_stall_wdog.sv
// Stall watchdog: saturating cycle counter with synchronous clear and a
// sticky timeout flag that only reset can clear.
module stall_wdog #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic timeout_o
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;
  logic            timeout_q;
  logic            timeout_d;

  // Next count: clear wins, otherwise count held cycles up to LIMIT and stop.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + TO_W'(1);
    end
    // The flag latches as soon as the count lands on LIMIT and never drops.
    timeout_d = timeout_q | (cnt_d == LIMIT);
  end

  // Counter and sticky flag registers, cleared by the active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller for the 3-stage core. Arbitrates EX
// redirects, long-latency EX and bus stalls, and interrupts, and produces
// the per-stage hold flags plus the PC redirect. Outputs are Mealy.
module pipe_hold_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int AW        = 32,
  parameter int FLUSH_CYC = 2,
  parameter int TO_W      = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_req_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          ex_hold_req_i,
  input  logic          bus_hold_req_i,
  input  logic          int_req_i,
  input  logic [AW-1:0] int_addr_i,
  output logic          int_ack_o,
  output logic [2:0]    hold_flag_o,
  output logic          jump_flag_o,
  output logic [AW-1:0] jump_addr_o,
  output logic          timeout_o
);

  // Flush counter only needs to hold FLUSH_CYC-1.
  localparam int            CW        = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CW-1:0] CNT_INIT  = CW'(FLUSH_CYC - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);
  localparam logic [1:0]    REDIR_ST  = redirect_state(FLUSH_CYC);

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] int_addr_q;
  logic [AW-1:0] int_addr_d;

  logic          hold_any;
  logic          wd_clr;
  logic          wd_inc;
  logic          wd_timeout;

  hold_flag_t    hold_flag;
  logic          jump_flag;
  logic [AW-1:0] jump_addr;
  logic          int_ack;

  assign hold_any = ex_hold_req_i | bus_hold_req_i;

  // Arbitration and next-state logic; priority is jump > hold > interrupt.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    int_addr_d = int_addr_q;
    hold_flag  = HOLD_NONE;
    jump_flag  = 1'b0;
    jump_addr  = '0;
    int_ack    = 1'b0;
    wd_clr     = 1'b0;
    wd_inc     = 1'b0;

    if (jump_req_i) begin
      // EX redirect overrides everything, including a pending interrupt
      // in INT (no ack, so the source keeps requesting) and any stall.
      jump_flag = 1'b1;
      jump_addr = jump_addr_i;
      hold_flag = FLUSH_JUMP;
      state_d   = REDIR_ST;
      cnt_d     = CNT_INIT;
      wd_clr    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hold_any) begin
            hold_flag = HOLD_ALL;
            wd_inc    = 1'b1;
            state_d   = ST_STALL;
          end else if (int_req_i) begin
            // Freeze the PC for one cycle while the vector is captured.
            hold_flag  = HOLD_PC_ONLY;
            int_addr_d = int_addr_i;
            state_d    = ST_INT;
          end
        end

        ST_FLUSH: begin
          if (hold_any) begin
            hold_flag = HOLD_ALL;
            wd_inc    = 1'b1;
            cnt_d     = '0;
            state_d   = ST_STALL;
          end else begin
            hold_flag = FLUSH_IFID_ONLY;
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CNT_LAST) begin
              state_d = ST_IDLE;
            end
          end
        end

        ST_STALL: begin
          if (hold_any) begin
            hold_flag = HOLD_ALL;
            wd_inc    = 1'b1;
          end else begin
            // Release cycle: pipeline moves again immediately.
            wd_clr  = 1'b1;
            state_d = ST_IDLE;
          end
        end

        ST_INT: begin
          // The interrupt is acknowledged here, so the redirect must be
          // issued now even if a stall arrives, or the vector would be lost.
          int_ack   = 1'b1;
          jump_flag = 1'b1;
          jump_addr = int_addr_q;
          if (hold_any) begin
            hold_flag = HOLD_ALL;
            wd_inc    = 1'b1;
            state_d   = ST_STALL;
          end else begin
            hold_flag = FLUSH_JUMP;
            state_d   = REDIR_ST;
            cnt_d     = CNT_INIT;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM state, flush counter and captured interrupt vector.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      int_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_addr_q <= int_addr_d;
    end
  end

  stall_wdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr),
    .inc_i     (wd_inc),
    .timeout_o (wd_timeout)
  );

  // Outputs are forced low for the whole reset cycle, not just after it.
  assign hold_flag_o = rst ? hold_flag  : HOLD_NONE;
  assign jump_flag_o = rst & jump_flag;
  assign jump_addr_o = rst ? jump_addr  : '0;
  assign int_ack_o   = rst & int_ack;
  assign timeout_o   = rst & wd_timeout;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Self-checking bench for pipe_hold_ctrl: a default instance and a
// TIMEOUT=4 instance share stimulus; each cycle's expected outputs are
// queued when driven and popped/compared mid-cycle.
module tb_pipe_hold_ctrl;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          jump_req;
  logic [AW-1:0] jump_addr;
  logic          ex_hold;
  logic          bus_hold;
  logic          int_req;
  logic [AW-1:0] int_addr;

  logic          int_ack;
  logic [2:0]    hold_flag;
  logic          jump_flag;
  logic [AW-1:0] jump_addr_out;
  logic          timeout;

  logic          int_ack4;
  logic [2:0]    hold_flag4;
  logic          jump_flag4;
  logic [AW-1:0] jump_addr_out4;
  logic          timeout4;

  always #5 clk = ~clk;

  pipe_hold_ctrl u_dut (
    .clk            (clk),
    .rst            (rst),
    .jump_req_i     (jump_req),
    .jump_addr_i    (jump_addr),
    .ex_hold_req_i  (ex_hold),
    .bus_hold_req_i (bus_hold),
    .int_req_i      (int_req),
    .int_addr_i     (int_addr),
    .int_ack_o      (int_ack),
    .hold_flag_o    (hold_flag),
    .jump_flag_o    (jump_flag),
    .jump_addr_o    (jump_addr_out),
    .timeout_o      (timeout)
  );

  pipe_hold_ctrl #(.TIMEOUT(4)) u_dut4 (
    .clk            (clk),
    .rst            (rst),
    .jump_req_i     (jump_req),
    .jump_addr_i    (jump_addr),
    .ex_hold_req_i  (ex_hold),
    .bus_hold_req_i (bus_hold),
    .int_req_i      (int_req),
    .int_addr_i     (int_addr),
    .int_ack_o      (int_ack4),
    .hold_flag_o    (hold_flag4),
    .jump_flag_o    (jump_flag4),
    .jump_addr_o    (jump_addr_out4),
    .timeout_o      (timeout4)
  );

  typedef struct {
    logic          r;
    logic          jr;
    logic [AW-1:0] ja;
    logic          ex;
    logic          bus;
    logic          ir;
    logic [AW-1:0] ia;
    logic [2:0]    e_hold;
    logic          e_jf;
    logic [AW-1:0] e_ja;
    logic          e_ack;
    logic          e_to;
    logic          e_to4;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  function automatic vec_t mk(input logic r, input logic jr, input logic [AW-1:0] ja,
                              input logic ex, input logic bus, input logic ir,
                              input logic [AW-1:0] ia, input logic [2:0] eh,
                              input logic ejf, input logic [AW-1:0] eja,
                              input logic eack, input logic eto, input logic eto4);
    vec_t v;
    v.r = r; v.jr = jr; v.ja = ja; v.ex = ex; v.bus = bus; v.ir = ir; v.ia = ia;
    v.e_hold = eh; v.e_jf = ejf; v.e_ja = eja; v.e_ack = eack;
    v.e_to = eto; v.e_to4 = eto4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, step_no, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at negedge.
  task automatic step(input vec_t v);
    vec_t e;
    rst       = v.r;
    jump_req  = v.jr;
    jump_addr = v.ja;
    ex_hold   = v.ex;
    bus_hold  = v.bus;
    int_req   = v.ir;
    int_addr  = v.ia;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk("hold_flag", {29'd0, hold_flag}, {29'd0, e.e_hold});
    chk("jump_flag", {31'd0, jump_flag}, {31'd0, e.e_jf});
    chk("jump_addr", jump_addr_out, e.e_ja);
    chk("int_ack",   {31'd0, int_ack}, {31'd0, e.e_ack});
    chk("timeout",   {31'd0, timeout}, {31'd0, e.e_to});
    chk("timeout_t4", {31'd0, timeout4}, {31'd0, e.e_to4});
    $display("step %0d rst=%b jr=%b ex=%b bus=%b ir=%b -> hold=%b jf=%b ja=0x%0h ack=%b to=%b to4=%b",
             step_no, v.r, v.jr, v.ex, v.bus, v.ir, hold_flag, jump_flag,
             jump_addr_out, int_ack, timeout, timeout4);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; jump_req = 1'b0; jump_addr = '0; ex_hold = 1'b0;
    bus_hold = 1'b0; int_req = 1'b0; int_addr = '0;

    // Reset with every request high, then a jump and its flush.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 32'h100, 1, 1, 1, 32'h80, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h100, 0, 0, 0, 0, 3'b110, 1, 32'h100, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    // EX hold for 5 cycles; the TIMEOUT=4 instance trips on the 5th.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 3'b111, 0, 0, 0, 0, (i == 4)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    // Interrupt: vector captured in the accept cycle, not the INT cycle.
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h80, 3'b001, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 32'h999, 3'b110, 1, 32'h80, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    // Jump abandons a stall and clears the watchdog; hold in FLUSH.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 3'b111, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'h2000, 0, 1, 0, 0, 3'b110, 1, 32'h2000, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 3'b111, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    // Reset in the middle of a flush aborts it.
    tbl.push_back(mk(1, 1, 32'h444, 0, 0, 0, 0, 3'b110, 1, 32'h444, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) step(tbl[i]);

    // Watchdog with TIMEOUT=4: bus hold for 10 cycles, flag is sticky.
    step(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      step(mk(1, 0, 0, 0, 1, 0, 0, 3'b111, 0, 0, 0, 0, (i >= 4)));
    for (int i = 0; i < 3; i++)
      step(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1));
    step(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));

    // Jump in the INT cycle wins; interrupt re-accepted after the flush.
    step(mk(1, 0, 0, 0, 0, 1, 32'h80, 3'b001, 0, 0, 0, 0, 0));
    step(mk(1, 1, 32'h300, 0, 0, 1, 32'h80, 3'b110, 1, 32'h300, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 1, 32'h80, 3'b010, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 1, 32'h80, 3'b001, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 1, 32'h80, 3'b110, 1, 32'h80, 1, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));

    // Hold beats interrupt in IDLE; hold arriving in INT still acks.
    step(mk(1, 0, 0, 1, 0, 1, 32'h80, 3'b111, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 1, 32'h80, 3'b000, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 1, 32'hC0, 3'b001, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 1, 0, 1, 32'hC0, 3'b111, 1, 32'hC0, 1, 0, 0));
    step(mk(1, 0, 0, 1, 0, 0, 0, 3'b111, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
